// File: rtl/masked_sbox_layer.sv
// masked_sbox_layer: pipelined, first-order 2-share masked PRINCE S-box layer.
// NSBOX nibbles are processed in parallel. Forward or inverse S-box is chosen per beat.
// Pipeline: stage 1 registers non-complete component functions, and stage 2
// compresses them into two output shares.
// Optional build macro MASK_REFRESH_EN adds the input port 'rnd'. That value is
// registered with the beat and XORed into both output shares at stage 2.
module masked_sbox_layer #(
  parameter int NSBOX = 16,
  localparam int W = 4 * NSBOX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [W-1:0] in_sh0,
  input  logic [W-1:0] in_sh1,
`ifdef MASK_REFRESH_EN
  input  logic [W-1:0] rnd,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_mode,
  output logic [W-1:0] out_sh0,
  output logic [W-1:0] out_sh1,
  output logic         busy
);

  // S-box truth tables. Entry x sits at bits [4x+3:4x].
  localparam logic [63:0] S_FWD = 64'h4D5E_0876_19CA_23FB;
  localparam logic [63:0] S_INV = 64'h1CE5_046A_98DF_237B;

  // Shared evaluation of one output bit of an S-box table.
  // The ANF of the bit is derived from the truth table; this is constant and
  // folds away in synthesis. Every monomial of the ANF is then expanded over
  // the two shares. Each expanded term is owned by exactly one share-index
  // pattern c (bit k of c picks the share of input bit k). Variables that are
  // absent from the monomial force c_k = 0, so each term lands in exactly one
  // component.
  // Component c therefore reads only share c_k of input bit k and never both
  // shares of one bit. XOR over all 16 components gives the unmasked bit.
  function automatic logic [15:0] compBits(input logic [63:0] tbl,
                                           input logic [1:0]  bitSel,
                                           input logic [3:0]  s0,
                                           input logic [3:0]  s1);
    logic [15:0] anf;
    logic [15:0] res;
    logic [3:0]  xv;
    logic [3:0]  pv;
    logic [3:0]  cv;
    logic [3:0]  mv;
    logic        term;
    anf = '0;
    res = '0;
    for (int x = 0; x < 16; x++) begin
      xv = 4'(x);
      anf[xv] = tbl[{xv, bitSel}];
    end
    for (int i = 0; i < 4; i++) begin
      pv = 4'(1 << i);
      for (int x = 0; x < 16; x++) begin
        xv = 4'(x);
        if ((xv & pv) != 4'b0) begin
          anf[xv] = anf[xv] ^ anf[xv ^ pv];
        end
      end
    end
    for (int c = 0; c < 16; c++) begin
      cv = 4'(c);
      for (int m = 0; m < 16; m++) begin
        mv = 4'(m);
        if (anf[mv] && ((cv & ~mv) == 4'b0)) begin
          term = 1'b1;
          for (int k = 0; k < 4; k++) begin
            pv = 4'(1 << k);
            if ((mv & pv) != 4'b0) begin
              term = term & (((cv & pv) != 4'b0) ? (|(s1 & pv)) : (|(s0 & pv)));
            end
          end
          res[cv] = res[cv] ^ term;
        end
      end
    end
    return res;
  endfunction

  // Handshake state.
  logic r_v1;
  logic r_v2;
  logic w_adv1;
  logic w_adv2;

  // Stage-1 component registers, indexed [nibble][output bit][share pattern].
  logic [NSBOX-1:0][3:0][15:0] w_compFwd;
  logic [NSBOX-1:0][3:0][15:0] w_compInv;
  logic [NSBOX-1:0][3:0][15:0] r_comp;
  logic                        r_mode1;

  // Compression results and stage-2 output registers.
  logic [W-1:0] w_cmp0;
  logic [W-1:0] w_cmp1;
  logic [W-1:0] w_next0;
  logic [W-1:0] w_next1;
  logic [W-1:0] r_sh0;
  logic [W-1:0] r_sh1;
  logic         r_mode2;

  assign w_adv2    = !r_v2 || out_ready;
  assign w_adv1    = !r_v1 || w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_v2;
  assign out_mode  = r_mode2;
  assign out_sh0   = r_sh0;
  assign out_sh1   = r_sh1;
  assign busy      = r_v1 || r_v2;

  // Component generation and compression, one slice per nibble and output bit.
  // Components with c[3] = 0 fold into share 0, and the rest fold into share 1.
  for (genvar gi = 0; gi < NSBOX; gi++) begin : g_nib
    for (genvar gb = 0; gb < 4; gb++) begin : g_bit
      assign w_compFwd[gi][gb] = compBits(S_FWD, 2'(gb), in_sh0[4*gi +: 4], in_sh1[4*gi +: 4]);
      assign w_compInv[gi][gb] = compBits(S_INV, 2'(gb), in_sh0[4*gi +: 4], in_sh1[4*gi +: 4]);
      assign w_cmp0[4*gi + gb] = ^r_comp[gi][gb][7:0];
      assign w_cmp1[4*gi + gb] = ^r_comp[gi][gb][15:8];
    end
  end

`ifdef MASK_REFRESH_EN
  logic [W-1:0] r_rnd;

  assign w_next0 = w_cmp0 ^ r_rnd;
  assign w_next1 = w_cmp1 ^ r_rnd;

  // Fresh randomness travels with the beat through stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rnd <= '0;
    end else if (w_adv1 && in_valid) begin
      r_rnd <= rnd;
    end
  end
`else
  assign w_next0 = w_cmp0;
  assign w_next1 = w_cmp1;
`endif

  // Stage 1 captures the component set for the selected direction when it can advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_comp  <= '0;
      r_mode1 <= 1'b0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_comp  <= in_mode ? w_compInv : w_compFwd;
        r_mode1 <= in_mode;
      end
    end
  end

  // Stage 2 registers the compressed shares and holds them steady while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_sh0   <= '0;
      r_sh1   <= '0;
      r_mode2 <= 1'b0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sh0   <= w_next0;
        r_sh1   <= w_next1;
        r_mode2 <= r_mode1;
      end
    end
  end

endmodule

// File: tb/tb_masked_sbox_layer.sv
// tb_masked_sbox_layer: self-checking bench for masked_sbox_layer (NSBOX = 16).
// A table-lookup model predicts every emitted beat, and a negedge monitor
// compares the DUT outputs against it.
module tb_masked_sbox_layer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [63:0] in_sh0;
  logic [63:0] in_sh1;
  logic        out_valid;
  logic        out_ready;
  logic        out_mode;
  logic [63:0] out_sh0;
  logic [63:0] out_sh1;
  logic        busy;
`ifdef MASK_REFRESH_EN
  logic [63:0] rnd;
`endif

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int lastStall = -1;
  int inFlight = 0;
  bit holdPending = 1'b0;
  logic        heldMode;
  logic [63:0] heldSh0;
  logic [63:0] heldSh1;

  typedef struct {
    logic        mode;
    logic [63:0] res;
    int          acc;
  } beat_t;
  beat_t q[$];

  logic [3:0] sFwd [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                            4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
  logic [3:0] sInv [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                            4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

  masked_sbox_layer #(.NSBOX(16)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_mode(in_mode),
    .in_sh0(in_sh0),
    .in_sh1(in_sh1),
`ifdef MASK_REFRESH_EN
    .rnd(rnd),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mode(out_mode),
    .out_sh0(out_sh0),
    .out_sh1(out_sh1),
    .busy(busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Unmasked reference: apply the selected table to every nibble.
  function automatic logic [63:0] model(input logic mode, input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = mode ? sInv[x[4*i +: 4]] : sFwd[x[4*i +: 4]];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one beat and hold it until accepted. The task is entered and left just after a rising edge.
  task automatic applyStimulus(input logic m, input logic [63:0] s0, input logic [63:0] s1);
    bit accepted;
    int waitCycles;
    accepted = 1'b0;
    waitCycles = 0;
    in_valid = 1'b1;
    in_mode = m;
    in_sh0 = s0;
    in_sh1 = s1;
    while (!accepted && waitCycles < 100) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
      waitCycles++;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: got no in_ready, expected acceptance within 100 cycles");
    end
  endtask

  // Single beat with the output always ready; check the result 2 cycles after accept.
  task automatic runDirected(input string name, input logic m, input logic [63:0] s0,
                             input logic [63:0] s1, input logic [63:0] exp,
                             output logic [63:0] got, output logic [63:0] got0);
    out_ready = 1'b1;
    applyStimulus(m, s0, s1);
    @(negedge clk);
    @(negedge clk);
    got = out_sh0 ^ out_sh1;
    got0 = out_sh0;
    checkOutput({name, "_valid"}, {63'b0, out_valid}, 64'd1);
    checkOutput({name, "_unmasked"}, got, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  // Monitor: track accepted beats and check every emitted beat, stall hold, in_ready and busy.
  always @(negedge clk) begin
    beat_t b;
    cycle++;
    if (rst) begin
      q.delete();
      inFlight = 0;
      holdPending = 1'b0;
    end else begin
      if (holdPending) begin
        checkOutput("hold_valid", {63'b0, out_valid}, 64'd1);
        checkOutput("hold_mode", {63'b0, out_mode}, {63'b0, heldMode});
        checkOutput("hold_sh0", out_sh0, heldSh0);
        checkOutput("hold_sh1", out_sh1, heldSh1);
      end
      checkOutput("in_ready", {63'b0, in_ready}, {63'b0, (inFlight < 2) || out_ready});
      checkOutput("busy", {63'b0, busy}, {63'b0, inFlight != 0});
      if (inFlight == 0) checkOutput("idle_out_valid", {63'b0, out_valid}, 64'd0);
      if (inFlight == 2) checkOutput("full_out_valid", {63'b0, out_valid}, 64'd1);
      if (out_valid && !out_ready) begin
        lastStall = cycle;
        holdPending = 1'b1;
        heldMode = out_mode;
        heldSh0 = out_sh0;
        heldSh1 = out_sh1;
      end else begin
        holdPending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checkOutput("unexpected_beat", out_sh0 ^ out_sh1, 64'bx);
        end else begin
          b = q.pop_front();
          checkOutput("beat_mode", {63'b0, out_mode}, {63'b0, b.mode});
          checkOutput("beat_unmasked", out_sh0 ^ out_sh1, b.res);
          if (lastStall < b.acc) checkOutput("beat_latency", 64'(cycle - b.acc), 64'd2);
          inFlight--;
        end
      end
      if (in_valid && in_ready) begin
        b.mode = in_mode;
        b.res = model(in_mode, in_sh0 ^ in_sh1);
        b.acc = cycle;
        q.push_back(b);
        inFlight++;
      end
    end
  end

  initial begin
    logic [63:0] got;
    logic [63:0] got0;
    logic [63:0] y;
    logic [63:0] msk;
    logic [63:0] s0;
    logic [63:0] s1;
    logic [7:0]  p;
    logic [7:0]  off;
    int          c0;
    bit          done;
    bit          sawStall;
    rst = 1'b1;
    in_valid = 1'b0;
    in_mode = 1'b0;
    in_sh0 = '0;
    in_sh1 = '0;
    out_ready = 1'b1;
`ifdef MASK_REFRESH_EN
    rnd = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("reset_busy", {63'b0, busy}, 64'd0);
    checkOutput("reset_in_ready", {63'b0, in_ready}, 64'd1);
    checkOutput("reset_sh0", out_sh0, 64'd0);
    checkOutput("reset_sh1", out_sh1, 64'd0);
    checkOutput("reset_mode", {63'b0, out_mode}, 64'd0);
    @(posedge clk);
    #1;

    // Hand-computed pins for the reference model.
    checkOutput("model_pin_zero", model(1'b0, 64'h0), 64'hBBBB_BBBB_BBBB_BBBB);
    checkOutput("model_pin_fwd", model(1'b0, 64'h0123_4567_89AB_CDEF), 64'hBF32_AC91_6780_E5D4);
    checkOutput("model_pin_inv", model(1'b1, 64'hFFFF_FFFF_FFFF_FFFF), 64'h1111_1111_1111_1111);

    // Directed known-answer beats.
    runDirected("t1_zero", 1'b0, 64'h0, 64'h0, 64'hBBBB_BBBB_BBBB_BBBB, got, got0);
    runDirected("t2_fwd_one", 1'b0, 64'h5555_5555_5555_5555, 64'h4444_4444_4444_4444,
                64'hFFFF_FFFF_FFFF_FFFF, got, got0);
    runDirected("t2_inv_f", 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
                64'h1111_1111_1111_1111, got, got0);

    // Round trip through S and then S^-1 with fresh masks.
    msk = {$urandom, $urandom};
    runDirected("t3_rt_fwd", 1'b0, 64'h0123_4567_89AB_CDEF ^ msk, msk,
                64'hBF32_AC91_6780_E5D4, y, got0);
    msk = {$urandom, $urandom};
    runDirected("t3_rt_inv", 1'b1, y ^ msk, msk, 64'h0123_4567_89AB_CDEF, got, got0);

    // Every per-nibble share pair in both modes, streamed back to back.
    for (int md = 0; md < 2; md++) begin
      off = 8'($urandom_range(255));
      c0 = cycle;
      for (int j = 0; j < 16; j++) begin
        for (int i = 0; i < 16; i++) begin
          p = 8'(j * 16 + i) + off;
          s0[4*i +: 4] = p[7:4];
          s1[4*i +: 4] = p[3:0];
        end
        applyStimulus(md[0], s0, s1);
      end
      checkOutput("throughput_cycles", 64'(cycle - c0), 64'd16);
    end
    drain();

    // Back-pressure: four beats streamed, output stalled for three cycles.
    sawStall = 1'b0;
    fork
      begin
        for (int b = 0; b < 4; b++) applyStimulus(1'($urandom_range(1)), {$urandom, $urandom}, {$urandom, $urandom});
      end
      begin
        out_ready = 1'b1;
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!in_ready) sawStall = 1'b1;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    checkOutput("bp_in_ready_dropped", {63'b0, sawStall}, 64'd1);
    drain();

    // Randomised traffic with random output stalls and input gaps.
    done = 1'b0;
    fork
      begin
        for (int b = 0; b < 300; b++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
`ifdef MASK_REFRESH_EN
          rnd = {$urandom, $urandom};
`endif
          applyStimulus(1'($urandom_range(1)), {$urandom, $urandom}, {$urandom, $urandom});
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    drain();

    // Reset with both stages full: everything in flight is discarded.
    out_ready = 1'b0;
    applyStimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom});
    applyStimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("t5_busy", {63'b0, busy}, 64'd0);
    checkOutput("t5_in_ready", {63'b0, in_ready}, 64'd1);
    checkOutput("t5_sh0", out_sh0, 64'd0);
    checkOutput("t5_sh1", out_sh1, 64'd0);
    checkOutput("t5_mode", {63'b0, out_mode}, 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end

`ifdef MASK_REFRESH_EN
    // Refresh randomness shifts both shares equally and leaves the unmasked value intact.
    rnd = 64'h0;
    runDirected("t6_rnd0", 1'b0, 64'h0, 64'h0, 64'hBBBB_BBBB_BBBB_BBBB, got, y);
    rnd = 64'hDEAD_BEEF_DEAD_BEEF;
    runDirected("t6_rnd", 1'b0, 64'h0, 64'h0, 64'hBBBB_BBBB_BBBB_BBBB, got, got0);
    checkOutput("t6_sh0_refresh", got0 ^ y, 64'hDEAD_BEEF_DEAD_BEEF);
`endif
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
